// File: rtl/riscv_mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port unified memory.
// Port 0 is the core (fetch + load/store), port 1 the loader/debug port.
// One access in flight; fixed memory latency; completion signalled by a
// one-cycle ack pulse to the granted port.
module riscv_mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 2    // 1..15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    // cnt starts at this value on entry to ACCESS, so it also marks the first
    // ACCESS cycle (the only one carrying mem_en).
    localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

    logic [1:0] state;
    logic [3:0] cnt;
    logic       last;     // port served most recently; loses the next tie
    logic       we_sel;
    logic       in_access;

    assign in_access = (state == ACCESS);
    assign we_sel    = owner ? we1 : we0;

    // Outputs decode registered state only, so requests never reach ack/mem_en
    // combinationally.
    always_comb begin
        busy      = (state != IDLE);
        ack0      = (state == RESP) && !owner;
        ack1      = (state == RESP) &&  owner;
        mem_en    = in_access && (cnt == CNT_INIT);
        mem_we    = mem_en && we_sel;
        mem_addr  = '0;
        mem_wdata = '0;
        if (in_access) begin
            mem_addr  = owner ? addr1  : addr0;
            mem_wdata = owner ? wdata1 : wdata0;
        end
    end

    // Arbitration FSM: IDLE grants, ACCESS waits out the latency and captures
    // read data, RESP pulses ack and records the served port.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            last   <= 1'b1;
            owner  <= 1'b0;
            rdata0 <= '0;
            rdata1 <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        owner <= (req0 && req1) ? ~last : req1;
                        cnt   <= CNT_INIT;
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        if (!we_sel) begin
                            if (owner) rdata1 <= mem_rdata;
                            else       rdata0 <= mem_rdata;
                        end
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    last  <= owner;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Bench for riscv_mem_arbiter: directed scenarios plus random two-port
// traffic, with a per-port expected-response scoreboard drained by a
// free-running monitor, and two extra instances at latency 1 and 15.
module tb_riscv_mem_arbiter;

    localparam int LAT = 2;

    typedef struct packed {
        logic        we;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        ack0, ack1, mem_en, mem_we, busy, owner;
    logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;

    int total = 0;
    int bad   = 0;

    exp_t q0[$];
    exp_t q1[$];

    bit go_lat = 1'b0;
    bit done_lat [2];

    always #5 clk = ~clk;

    riscv_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(LAT)) u_dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .owner(owner)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 30) $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic checkb(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 30) $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    // Memory initial contents: word 4 (byte 0x10) holds DEADBEEF, others a pattern.
    function automatic logic [31:0] init_val(input logic [6:0] i);
        return (i == 7'd4) ? 32'hDEADBEEF : (32'h5A00_0000 | ({25'd0, i} * 32'h0001_0101));
    endfunction

    // Memory macro model: valid data appears LAT-1 cycles after the mem_en cycle,
    // garbage at any other time so a mistimed capture is visible.
    logic [31:0] mem [0:127];
    logic [127:0] wr_bit = '0;
    int          age = 100;
    logic [6:0]  midx;
    assign midx = mem_addr[8:2];

    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            mem[midx]    <= mem_wdata;
            wr_bit[midx] <= 1'b1;
        end
        age <= mem_en ? 1 : ((age < 100) ? age + 1 : age);
    end

    assign mem_rdata = (((mem_en ? 0 : age) == LAT - 1)) ?
                       (wr_bit[midx] ? mem[midx] : init_val(midx)) : 32'hBADC0FFE;

    // Reference memory: what each requester should observe, updated at issue time.
    logic [31:0] ref_mem [0:127];
    bit          ref_wr  [0:127];

    function automatic logic [31:0] ref_val(input logic [6:0] i);
        return ref_wr[i] ? ref_mem[i] : init_val(i);
    endfunction

    task automatic issue_exp(input int p, input logic w, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        logic [6:0] i;
        i = a[8:2];
        e.we = w;
        e.data = '0;
        if (w) begin
            ref_mem[i] = d;
            ref_wr[i]  = 1'b1;
        end else begin
            e.data = ref_val(i);
        end
        if (p == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // One access on port p; returns cycles from the sampling cycle to ack.
    task automatic access(input int p, input logic w, input logic [31:0] a,
                          input logic [31:0] d, output int lat);
        bit got;
        got = 1'b0;
        issue_exp(p, w, a, d);
        @(posedge clk); #1;
        if (p == 0) begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
        else        begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
        lat = 0;
        for (int i = 1; i <= 60 && !got; i++) begin
            @(negedge clk);
            lat = i;
            got = (p == 0) ? ack0 : ack1;
        end
        checkb("ack_timeout", got, 1'b1);
        @(posedge clk); #1;
        if (p == 0) req0 = 1'b0;
        else        req1 = 1'b0;
        lat = lat - 1;
    endtask

    // Monitor: abstract model of the arbiter (idle / phase since grant, last
    // served port); pops the scoreboard on every ack.
    initial begin : mon
        int   phase;
        logic mlast, mown, armed, aown, aoth;
        logic [31:0] hold0, hold1;
        exp_t e;
        phase = -1; mlast = 1'b1; mown = 1'b0; armed = 1'b0;
        hold0 = '0; hold1 = '0;
        forever begin
            @(negedge clk);
            if (armed) begin
                if (phase < 0) begin
                    checkb("idle_busy", busy, 1'b0);
                    checkb("idle_en", mem_en, 1'b0);
                    checkb("idle_we", mem_we, 1'b0);
                    checkb("idle_ack0", ack0, 1'b0);
                    checkb("idle_ack1", ack1, 1'b0);
                    checkb("idle_owner", owner, mown);
                    check("idle_addr", mem_addr, 32'h0);
                    check("idle_wdata", mem_wdata, 32'h0);
                end else begin
                    aown = mown ? ack1 : ack0;
                    aoth = mown ? ack0 : ack1;
                    checkb("busy", busy, 1'b1);
                    checkb("owner", owner, mown);
                    checkb("mem_en", mem_en, phase == 1);
                    checkb("mem_we", mem_we, (phase == 1) && (mown ? we1 : we0));
                    checkb("ack_owner", aown, phase == LAT + 1);
                    checkb("ack_other", aoth, 1'b0);
                    if (phase <= LAT) begin
                        check("mem_addr", mem_addr, mown ? addr1 : addr0);
                        check("mem_wdata", mem_wdata, mown ? wdata1 : wdata0);
                    end else begin
                        check("resp_addr", mem_addr, 32'h0);
                    end
                    if (phase == LAT + 1) begin
                        if ((mown ? q1.size() : q0.size()) == 0) begin
                            total++; bad++;
                            if (bad <= 30) $display("FAIL sb_empty: got ack on port %0d want none", mown);
                        end else begin
                            if (mown) e = q1.pop_front();
                            else      e = q0.pop_front();
                            if (!e.we) begin
                                if (mown) hold1 = e.data;
                                else      hold0 = e.data;
                            end
                        end
                    end
                end
                check("rdata0", rdata0, hold0);
                check("rdata1", rdata1, hold1);
            end
            if (reset) begin
                phase = -1; mlast = 1'b1; mown = 1'b0;
                hold0 = '0; hold1 = '0; armed = 1'b1;
            end else if (armed) begin
                if (phase < 0) begin
                    if (req0 || req1) begin
                        mown  = (req0 && req1) ? !mlast : req1;
                        phase = 1;
                    end
                end else if (phase == LAT + 1) begin
                    mlast = mown;
                    phase = -1;
                end else begin
                    phase++;
                end
            end
        end
    end

    // Latency-1 and latency-15 builds, each doing a single read.
    for (genvar g = 0; g < 2; g++) begin : g_lat
        localparam int LL = (g == 0) ? 1 : 15;
        logic        rst, rq, ak0, ak1, men, mwe, bsy, own;
        logic [31:0] rd0, rd1, ma, mwd, mrd;
        int          ag = 100;

        riscv_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(LL)) u_lat (
            .clk(clk), .reset(rst),
            .req0(rq), .req1(1'b0), .we0(1'b0), .we1(1'b0),
            .addr0(32'h44), .addr1(32'h0), .wdata0(32'h0), .wdata1(32'h0),
            .ack0(ak0), .ack1(ak1), .rdata0(rd0), .rdata1(rd1),
            .mem_en(men), .mem_we(mwe), .mem_addr(ma), .mem_wdata(mwd),
            .mem_rdata(mrd), .busy(bsy), .owner(own)
        );

        always @(posedge clk) ag <= men ? 1 : ((ag < 100) ? ag + 1 : ag);
        assign mrd = (((men ? 0 : ag) == LL - 1)) ? (ma ^ 32'hA5A5_0000) : 32'hBAD0_BAD0;

        initial begin
            int n, en_cnt;
            bit got;
            rst = 1'b1; rq = 1'b0; got = 1'b0; n = 0; en_cnt = 0;
            wait (go_lat);
            repeat (2) @(posedge clk);
            #1 rst = 1'b0; rq = 1'b1;
            for (int i = 1; i <= 40 && !got; i++) begin
                @(negedge clk);
                n = i;
                if (men) en_cnt++;
                got = ak0;
            end
            checkb("lat_ack", got, 1'b1);
            check("lat_cycles", n - 1, LL + 1);
            check("lat_rdata0", rd0, 32'h44 ^ 32'hA5A5_0000);
            check("lat_en_count", en_cnt, 1);
            @(posedge clk); #1 rq = 1'b0;
            @(negedge clk);
            check("lat_idle", 32'({ak1, bsy, own, mwe, |mwd, |rd1}), 32'h0);
            done_lat[g] = 1'b1;
        end
    end

    // Stimulus: directed scenarios, random traffic, then the latency builds.
    initial begin
        int   lat, nack;
        int   at [4];
        logic ord [4];
        for (int i = 0; i < 128; i++) ref_wr[i] = 1'b0;
        for (int k = 0; k < 4; k++) begin at[k] = 0; ord[k] = 1'b0; end
        reset = 1'b1; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkb("rst_busy", busy, 1'b0);
        checkb("rst_en", mem_en, 1'b0);
        checkb("rst_ack0", ack0, 1'b0);
        checkb("rst_ack1", ack1, 1'b0);
        checkb("rst_owner", owner, 1'b0);
        check("rst_rdata0", rdata0, 32'h0);
        check("rst_rdata1", rdata1, 32'h0);

        // Single read on port 0.
        access(0, 1'b0, 32'h10, 32'h0, lat);
        check("t1_lat", lat, LAT + 1);
        check("t1_rdata0", rdata0, 32'hDEADBEEF);

        // Port 1 write, read back through port 0.
        access(1, 1'b1, 32'h20, 32'h12345678, lat);
        check("t2_lat", lat, LAT + 1);
        access(0, 1'b0, 32'h20, 32'h0, lat);
        check("t2_readback", rdata0, 32'h12345678);

        // Both ports requesting continuously from reset: strict alternation.
        @(posedge clk); #1 reset = 1'b1;
        issue_exp(0, 1'b0, 32'h40, 32'h0);  issue_exp(0, 1'b0, 32'h40, 32'h0);
        issue_exp(1, 1'b0, 32'h140, 32'h0); issue_exp(1, 1'b0, 32'h140, 32'h0);
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h40;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'h140;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        nack = 0;
        for (int i = 0; i < 60 && nack < 4; i++) begin
            @(negedge clk);
            if (ack0 || ack1) begin ord[nack] = ack1; at[nack] = i; nack++; end
        end
        @(posedge clk); #1 req0 = 1'b0; req1 = 1'b0;
        check("t3_nack", nack, 4);
        for (int k = 0; k < 4; k++) checkb("t3_order", ord[k], k[0]);
        for (int k = 1; k < 4; k++) check("t3_gap", at[k] - at[k-1], LAT + 2);

        // Reset in the second ACCESS cycle, request kept high.
        @(posedge clk); #1;
        issue_exp(0, 1'b0, 32'h30, 32'h0);
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h30;
        @(posedge clk); #1;
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        checkb("t4_ack0", ack0, 1'b0);
        checkb("t4_en", mem_en, 1'b0);
        checkb("t4_busy", busy, 1'b0);
        lat = 0;
        for (int i = 1; i <= 40 && !ack0; i++) begin @(negedge clk); lat = i; end
        checkb("t4_reissue_ack", ack0, 1'b1);
        check("t4_reissue_lat", lat, LAT + 1);
        @(posedge clk); #1 req0 = 1'b0;

        // Random traffic, disjoint address regions per port.
        fork
            for (int k = 0; k < 700; k++) begin
                int l0;
                repeat ($urandom_range(0, 3)) @(posedge clk);
                access(0, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)) << 2, $urandom, l0);
                checkb("t6_wait0", l0 <= 2 * (LAT + 2), 1'b1);
            end
            for (int k = 0; k < 700; k++) begin
                int l1;
                repeat ($urandom_range(0, 3)) @(posedge clk);
                access(1, 1'($urandom_range(0, 1)), 32'h100 | (32'($urandom_range(0, 63)) << 2), $urandom, l1);
                checkb("t6_wait1", l1 <= 2 * (LAT + 2), 1'b1);
            end
        join

        // Latency-1 / latency-15 builds.
        go_lat = 1'b1;
        for (int i = 0; i < 200 && !(done_lat[0] && done_lat[1]); i++) @(negedge clk);
        checkb("lat_done", done_lat[0] && done_lat[1], 1'b1);

        repeat (4) @(negedge clk);
        check("sb_left0", q0.size(), 0);
        check("sb_left1", q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
